// File: rtl/ka26_pkg.sv
// rtl/ka26_pkg.sv - shared constants and FSM state type for the 26-bit Karatsuba split
// KA26_DIGIT2_EN: consume two multiplier bits per MUL step instead of one
package ka26_pkg;

  localparam int N   = 26;
  localparam int H   = 13;
  localparam int PW  = 2*H-1;
  localparam int K_W = 4;

`ifdef KA26_DIGIT2_EN
  localparam int             DIGIT     = 2;
  localparam logic [K_W-1:0] LAST_STEP = 4'd6;
  localparam logic [K_W-1:0] LAST_K    = 4'd12;
`else
  localparam int             DIGIT     = 1;
  localparam logic [K_W-1:0] LAST_STEP = 4'd12;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

endpackage

// File: rtl/gf2_shacc_13bit.sv
// rtl/gf2_shacc_13bit.sv - 13x13 carry-less bit-serial shift-XOR accumulator
// KA26_DIGIT2_EN: also folds in bit k+1 each step (bit 12 handled alone)
module gf2_shacc_13bit
  import ka26_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [K_W-1:0] i_k,
  input  logic [H-1:0]   i_a,
  input  logic [H-1:0]   i_b,
  output logic [PW-1:0]  o_acc
);

  logic [H-1:0]  r_a;
  logic [H-1:0]  r_b;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_acc_nxt;

  assign w_a_ext = {{(PW-H){1'b0}}, r_a};

  always_comb begin
    w_acc_nxt = r_acc;
    if (r_b[i_k]) w_acc_nxt = w_acc_nxt ^ (w_a_ext << i_k);
`ifdef KA26_DIGIT2_EN
    if ((i_k < LAST_K) && r_b[i_k + 4'd1]) w_acc_nxt = w_acc_nxt ^ (w_a_ext << (i_k + 4'd1));
`endif
  end

  // o_acc already includes the step being applied this cycle, so the
  // top can capture the finished product on the last step's edge.
  assign o_acc = w_acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/karatsuba_split_26bit.sv
// rtl/karatsuba_split_26bit.sv - sequential GF(2) Karatsuba front-end producing low/mid/high terms
// KA26_DIGIT2_EN: two bits per MUL step (7 steps instead of 13)
module karatsuba_split_26bit
  import ka26_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p_lo,
  output logic [PW-1:0] p_mid,
  output logic [PW-1:0] p_hi
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [K_W-1:0] r_step;
  logic [K_W-1:0] w_k;
  logic           r_out_valid;
  logic [PW-1:0]  r_p_lo;
  logic [PW-1:0]  r_p_mid;
  logic [PW-1:0]  r_p_hi;
  logic           w_load;
  logic           w_step;
  logic           w_last;
  logic [PW-1:0]  w_acc_l;
  logic [PW-1:0]  w_acc_h;
  logic [PW-1:0]  w_acc_m;
  logic [H-1:0]   w_a0;
  logic [H-1:0]   w_a1;
  logic [H-1:0]   w_b0;
  logic [H-1:0]   w_b1;

  assign w_a0 = a_in[H-1:0];
  assign w_a1 = a_in[N-1:H];
  assign w_b0 = b_in[H-1:0];
  assign w_b1 = b_in[N-1:H];

  assign w_load = (r_state == IDLE) && in_valid;
  assign w_step = (r_state == MUL);
  assign w_last = w_step && (r_step == LAST_STEP);
  assign w_k    = (DIGIT == 2) ? {r_step[K_W-2:0], 1'b0} : r_step;

  gf2_shacc_13bit u_lo (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_step(w_step), .i_k(w_k),
    .i_a(w_a0), .i_b(w_b0), .o_acc(w_acc_l)
  );

  gf2_shacc_13bit u_hi (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_step(w_step), .i_k(w_k),
    .i_a(w_a1), .i_b(w_b1), .o_acc(w_acc_h)
  );

  gf2_shacc_13bit u_mid (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_step(w_step), .i_k(w_k),
    .i_a(w_a0 ^ w_a1), .i_b(w_b0 ^ w_b1), .o_acc(w_acc_m)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = MUL;
      MUL:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_p_lo      <= '0;
      r_p_mid     <= '0;
      r_p_hi      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load || w_last) r_step <= '0;
      else if (w_step)      r_step <= r_step + 4'd1;
      // Middle correction folds out the low and high terms before hand-off.
      if (w_last) begin
        r_p_lo      <= w_acc_l;
        r_p_hi      <= w_acc_h;
        r_p_mid     <= w_acc_m ^ w_acc_l ^ w_acc_h;
        r_out_valid <= 1'b1;
      end else if ((r_state == DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign p_lo      = r_p_lo;
  assign p_mid     = r_p_mid;
  assign p_hi      = r_p_hi;

endmodule

// File: tb/tb_karatsuba_split_26bit.sv
// tb/tb_karatsuba_split_26bit.sv - directed and reference-model bench for karatsuba_split_26bit
// KA26_DIGIT2_EN: selects the shorter expected latency
module tb_karatsuba_split_26bit;

`ifdef KA26_DIGIT2_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 13;
`endif
  localparam int II = LAT + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] a_in;
  logic [25:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] p_lo;
  logic [24:0] p_mid;
  logic [24:0] p_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  karatsuba_split_26bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .p_lo(p_lo), .p_mid(p_mid), .p_hi(p_hi)
  );

  function automatic logic [50:0] clmul(input logic [25:0] a, input logic [25:0] b);
    logic [50:0] r;
    r = '0;
    for (int i = 0; i < 26; i++) if (b[i]) r = r ^ ({25'b0, a} << i);
    return r;
  endfunction

  function automatic logic [50:0] overlap(input logic [24:0] lo, input logic [24:0] mid, input logic [24:0] hi);
    return {26'b0, lo} ^ ({26'b0, mid} << 13) ^ ({26'b0, hi} << 26);
  endfunction

  task automatic do_op(input logic [25:0] a, input logic [25:0] b, output int lat);
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    checks++;
    if (p_lo !== 25'h0 || p_mid !== 25'h0 || p_hi !== 25'h0) begin
      errors++; $display("FAIL reset_p: got %h/%h/%h, required 0/0/0", p_lo, p_mid, p_hi);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [25:0] a;
    logic [25:0] b;
    logic [24:0] lo;
    logic [24:0] mid;
    logic [24:0] hi;
  } vec_t;

  task automatic test_directed;
    vec_t v[6];
    int lat;
    v[0] = '{26'h0000001, 26'h0000001, 25'h1,       25'h0,    25'h0};
    v[1] = '{26'h0002000, 26'h0002000, 25'h0,       25'h0,    25'h1};
    v[2] = '{26'h3FFFFFF, 26'h0000001, 25'h1FFF,    25'h1FFF, 25'h0};
    v[3] = '{26'h0000003, 26'h0000003, 25'h5,       25'h0,    25'h0};
    v[4] = '{26'h0002000, 26'h0000001, 25'h0,       25'h1,    25'h0};
    v[5] = '{26'h3FFFFFF, 26'h3FFFFFF, 25'h1555555, 25'h0,    25'h1555555};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].a, v[i].b, lat);
      checks++;
      if (lat != LAT) begin
        errors++; $display("FAIL dir%0d_latency: got %0d edges, required %0d", i, lat, LAT);
      end
      checks++;
      if (p_lo !== v[i].lo || p_mid !== v[i].mid || p_hi !== v[i].hi) begin
        errors++; $display("FAIL dir%0d_result: got %h/%h/%h, required %h/%h/%h",
                           i, p_lo, p_mid, p_hi, v[i].lo, v[i].mid, v[i].hi);
      end
      finish_op();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_handshake: out_valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    do_op(26'h0000003, 26'h0000003, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; a_in = 26'h1234567; b_in = 26'h2ABCDEF;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall%0d_hs: out_valid=%b in_ready=%b, required 1/0", c, out_valid, in_ready);
      end
      checks++;
      if (p_lo !== 25'h5 || p_mid !== 25'h0 || p_hi !== 25'h0) begin
        errors++; $display("FAIL stall%0d_p: got %h/%h/%h, required 5/0/0", c, p_lo, p_mid, p_hi);
      end
    end
    in_valid = 1'b0;
    finish_op();
    checks++;
    if (p_lo !== 25'h5 || p_mid !== 25'h0 || p_hi !== 25'h0) begin
      errors++; $display("FAIL stall_retain: got %h/%h/%h, required 5/0/0", p_lo, p_mid, p_hi);
    end
    repeat (LAT + 3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_ignored: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int acc_cyc[$];
    logic [50:0] exp_p;
    exp_p = clmul(26'h2ABCDEF, 26'h1234567);
    @(negedge clk);
    a_in = 26'h2ABCDEF; b_in = 26'h1234567; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3 * II + 4; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) acc_cyc.push_back(c);
      if (out_valid === 1'b1) begin
        checks++;
        if (overlap(p_lo, p_mid, p_hi) !== exp_p) begin
          errors++; $display("FAIL b2b_result: got %h, required %h", overlap(p_lo, p_mid, p_hi), exp_p);
        end
      end
    end
    in_valid = 1'b0;
    repeat (2 * II) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (acc_cyc.size() < 3) begin
      errors++; $display("FAIL b2b_count: got %0d accepts, required at least 3", acc_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != II) begin
          errors++; $display("FAIL b2b_ii: got %0d cycles, required %0d", acc_cyc[i] - acc_cyc[i-1], II);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [25:0] a;
    logic [25:0] b;
    logic [50:0] exp_p;
    for (int i = 0; i < 1000; i++) begin
      a = 26'($urandom);
      b = 26'($urandom);
      exp_p = clmul(a, b);
      do_op(a, b, lat);
      checks++;
      if (lat != LAT || overlap(p_lo, p_mid, p_hi) !== exp_p) begin
        errors++; $display("FAIL rand%0d: a=%h b=%h got %h lat %0d, required %h lat %0d",
                           i, a, b, overlap(p_lo, p_mid, p_hi), lat, exp_p, LAT);
      end
      finish_op();
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    a_in = 26'h3FFFFFF; b_in = 26'h3FFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_hs: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    checks++;
    if (p_lo !== 25'h0 || p_mid !== 25'h0 || p_hi !== 25'h0) begin
      errors++; $display("FAIL rstmid_p: got %h/%h/%h, required 0/0/0", p_lo, p_mid, p_hi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(26'h0002000, 26'h0000001, lat);
    checks++;
    if (lat != LAT || p_lo !== 25'h0 || p_mid !== 25'h1 || p_hi !== 25'h0) begin
      errors++; $display("FAIL rstmid_fresh: got %h/%h/%h lat %0d, required 0/1/0 lat %0d",
                         p_lo, p_mid, p_hi, lat, LAT);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
